veda_mem_arbiter: RTL and testbench

Two-port access controller for the 32 x 8 `veda_mem` scratch memory. It arbitrates between requester A and requester B, sequences each winning request into the memory's addressed-register mode (Mode=1), and returns an acknowledge and, for reads, read data. It sits between the two client blocks and the single `veda_mem` instance. It is the only driver of the memory's control inputs.

---
 rtl/veda_mem_ctrl_pkg.sv | 19 +
 rtl/veda_rr_arb.sv | 44 ++++
 rtl/veda_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_veda_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/veda_mem_ctrl_pkg.sv
// Shared types and defaults for the veda_mem access controller.
package veda_mem_ctrl_pkg;

    localparam int unsigned AddrWDefault = 5;
    localparam int unsigned DataWDefault = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_t;

    typedef enum logic {
        ReqA = 1'b0,
        ReqB = 1'b1
    } req_id_t;

endpackage

// File: rtl/veda_rr_arb.sv
// 2-way grant logic. VEDA_ARB_RR_EN selects round-robin with a last-grant
// pointer; otherwise requester A has fixed priority.
module veda_rr_arb
    import veda_mem_ctrl_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    req_a_i,
    input  logic    req_b_i,
    input  logic    grant_en_i,
    output req_id_t gnt_o,
    output logic    gnt_valid_o
);

    assign gnt_valid_o = req_a_i | req_b_i;

`ifdef VEDA_ARB_RR_EN
    req_id_t last_q;

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= ReqB;
        end else if (grant_en_i && gnt_valid_o) begin
            last_q <= gnt_o;
        end
    end

    always_comb begin
        gnt_o = ReqA;
        if (req_a_i && req_b_i) begin
            gnt_o = (last_q == ReqA) ? ReqB : ReqA;
        end else if (req_b_i) begin
            gnt_o = ReqB;
        end
    end
`else
    logic unused_fixed;
    assign unused_fixed = ^{clk_i, rst_ni, grant_en_i};

    assign gnt_o = req_a_i ? ReqA : (req_b_i ? ReqB : ReqA);
`endif

endmodule

// File: rtl/veda_mem_arbiter.sv
// Two-port access controller for the veda_mem scratch memory (Mode=1).
// Tie-break policy is selected by VEDA_ARB_RR_EN (see veda_rr_arb).
module veda_mem_arbiter
    import veda_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = AddrWDefault,
    parameter int unsigned DATA_W  = DataWDefault,
    parameter int unsigned RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_Mode,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned CntW = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT);

    arb_state_t        state_q, state_d;
    req_id_t           cmd_id_q, cmd_id_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    req_id_t gnt;
    logic    gnt_valid;
    logic    grant_en;

    veda_rr_arb u_arb (
        .clk_i       (clk),
        .rst_ni      (rst),
        .req_a_i     (a_req),
        .req_b_i     (b_req),
        .grant_en_i  (grant_en),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cmd_id_q    <= ReqA;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        grant_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    grant_en    = 1'b1;
                    cmd_id_d    = gnt;
                    cmd_we_d    = (gnt == ReqA) ? a_we : b_we;
                    cmd_addr_d  = (gnt == ReqA) ? a_addr : b_addr;
                    cmd_wdata_d = (gnt == ReqA) ? a_wdata : b_wdata;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (cmd_we_q) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = CntW'(RD_WAIT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                // Memory needs one edge for the address register, one for q.
                if (cnt_q == '0) begin
                    if (cmd_id_q == ReqA) begin
                        a_rdata_d = mem_q;
                    end else begin
                        b_rdata_d = mem_q;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address/data come straight from the command register so they hold between accesses.
    assign mem_we      = (state_q == StIssue) && cmd_we_q;
    assign mem_address = cmd_addr_q;
    assign mem_dataIn  = cmd_wdata_q;
    assign mem_Mode    = 1'b1;

    assign a_ack   = (state_q == StResp) && (cmd_id_q == ReqA);
    assign b_ack   = (state_q == StResp) && (cmd_id_q == ReqB);
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_veda_mem_arbiter.sv
// Directed bench for veda_mem_arbiter with a behavioural veda_mem (Mode=1) model.
module tb_veda_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [4:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_we, mem_Mode;
    logic [4:0] mem_address;
    logic [7:0] mem_dataIn;
    logic [7:0] mem_q;

    int checks = 0;
    int failures = 0;

    veda_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_ack       (a_ack),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_ack       (b_ack),
        .b_rdata     (b_rdata),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_dataIn  (mem_dataIn),
        .mem_Mode    (mem_Mode),
        .mem_q       (mem_q)
    );

    always #5 clk = ~clk;

    // Addressed-register memory: address registered on one edge, q on the next.
    logic [7:0] mem [32];
    logic [4:0] mem_areg;
    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_dataIn;
        mem_areg <= mem_address;
        mem_q    <= mem[mem_areg];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_ack"}, 32'(a_ack), 0);
        check({tag, "_b_ack"}, 32'(b_ack), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_address"}, 32'(mem_address), 0);
        check({tag, "_mem_dataIn"}, 32'(mem_dataIn), 0);
        check({tag, "_a_rdata"}, 32'(a_rdata), 0);
        check({tag, "_b_rdata"}, 32'(b_rdata), 0);
        check({tag, "_mem_Mode"}, 32'(mem_Mode), 1);
    endtask

    task automatic access(input int id, input logic we, input logic [4:0] addr,
                          input logic [7:0] wd, input int exp_lat, input logic [7:0] exp_rd,
                          input string tag);
        int   lat;
        logic other;
        logic got;
        lat = 0;
        other = 1'b0;
        got = 1'b0;
        if (id == 0) begin
            a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end else begin
            b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end
        while (!got && lat < 20) begin
            tick();
            lat++;
            if ((id == 0) ? a_ack : b_ack) got = 1'b1;
            if ((id == 0) ? b_ack : a_ack) other = 1'b1;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_other_ack"}, 32'(other), 0);
        if (!we) check({tag, "_rdata"}, 32'((id == 0) ? a_rdata : b_rdata), 32'(exp_rd));
        if (id == 0) a_req = 1'b0;
        else b_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_id, second_id, n, na, nb, last, alt_err, lat;
        logic got;

        rst = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        #3;
        check_reset_outputs("reset");
        tick();
        #2 rst = 1'b1;
        tick();

        // A writes 0xA5 to address 3
        a_we = 1; a_addr = 5'd3; a_wdata = 8'hA5; a_req = 1;
        tick();
        check("wr_issue_mem_we", 32'(mem_we), 1);
        check("wr_issue_addr", 32'(mem_address), 3);
        check("wr_issue_data", 32'(mem_dataIn), 32'hA5);
        check("wr_issue_a_ack", 32'(a_ack), 0);
        tick();
        check("wr_resp_a_ack", 32'(a_ack), 1);
        check("wr_resp_mem_we", 32'(mem_we), 0);
        check("wr_resp_b_ack", 32'(b_ack), 0);
        a_req = 0;
        tick();
        check("wr_idle_addr_hold", 32'(mem_address), 3);
        check("wr_idle_a_ack", 32'(a_ack), 0);

        access(0, 1'b0, 5'd3, 8'h00, 4, 8'hA5, "rd_a3");

        // Fresh reset so the last-grant pointer is back at B.
        #2 rst = 1'b0;
        tick();
        #2 rst = 1'b1;
        tick();

        a_we = 1; a_addr = 5'd0; a_wdata = 8'h11;
        b_we = 1; b_addr = 5'd31; b_wdata = 8'h22;
        a_req = 1; b_req = 1;
        first_id = -1; second_id = -1; n = 0; lat = 0;
        while (n < 2 && lat < 30) begin
            tick();
            lat++;
            if (a_ack || b_ack) begin
                if (n == 0) first_id = a_ack ? 0 : 1;
                else second_id = a_ack ? 0 : 1;
                n++;
            end
        end
        check("tie_first", 32'(first_id), 0);
`ifdef VEDA_ARB_RR_EN
        check("tie_second", 32'(second_id), 1);
        a_req = 0; b_req = 0;
        tick();
`else
        check("tie_second", 32'(second_id), 0);
        a_req = 0;
        got = 0; lat = 0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (b_ack) got = 1;
        end
        check("tie_b_served", 32'(got), 1);
        b_req = 0;
        tick();
`endif

        access(0, 1'b0, 5'd0, 8'h00, 4, 8'h11, "rd_a0");
        access(1, 1'b0, 5'd31, 8'h00, 4, 8'h22, "rd_b31");

        // Continuous requests from both sides
        a_we = 1; a_addr = 5'd5; a_wdata = 8'h55;
        b_we = 1; b_addr = 5'd6; b_wdata = 8'h66;
        a_req = 1; b_req = 1;
        na = 0; nb = 0; last = -1; alt_err = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_ack) begin
                na++;
                if (last == 0) alt_err++;
                last = 0;
            end
            if (b_ack) begin
                nb++;
                if (last == 1) alt_err++;
                last = 1;
            end
        end
`ifdef VEDA_ARB_RR_EN
        check("cont_b_acked", 32'(nb > 3), 1);
        check("cont_alternate", 32'(alt_err), 0);
`else
        check("cont_b_starved", 32'(nb), 0);
        check("cont_a_acked", 32'(na > 10), 1);
`endif
        a_req = 0; b_req = 0;
        repeat (8) tick();

        // Reset during WAIT of a read
        a_we = 0; a_addr = 5'd3; a_req = 1;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        a_req = 0;
        tick();
        check("rst_hold_a_ack", 32'(a_ack), 0);
        #2 rst = 1'b1;
        tick();
        check("rst_rel_a_ack", 32'(a_ack), 0);
        access(0, 1'b0, 5'd3, 8'h00, 4, 8'hA5, "rd_retry");

        // Back-to-back B reads with b_req held
        b_we = 0; b_addr = 5'd31; b_req = 1;
        got = 0; lat = 0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (b_ack) got = 1;
        end
        check("b2b_first_lat", 32'(lat), 4);
        check("b2b_first_rdata", 32'(b_rdata), 32'h22);
        b_addr = 5'd0;
        got = 0; lat = 0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (b_ack) got = 1;
        end
        check("b2b_spacing", 32'(lat), 5);
        check("b2b_second_rdata", 32'(b_rdata), 32'h11);
        check("b2b_a_ack", 32'(a_ack), 0);
        b_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
